// File: rtl/neopixel_top.sv
// NeoPixel demo top: single-pixel chaser animation serialised as a WS2812 stream,
// plus a heartbeat LED. One clock domain, async active-low reset.
module neopixel_top #(
  parameter int C_SIM_MODE     = 0,
  parameter int C_CONTROL_RATE = 8000,
  parameter int C_PIXEL_COUNT  = 12
) (
  input  logic clock_125m,
  input  logic reset_125m,
  output logic neopixel_drive1,
  output logic leds
);

  localparam int BIT_PERIOD = 156;
  localparam int T1_HIGH    = 100;
  localparam int T0_HIGH    = 50;
  localparam int LATCH_CLKS = (C_SIM_MODE != 0) ? 400 : 10000;
  localparam int HB_DIV     = (C_SIM_MODE != 0) ? 1024 : 62_500_000;

  localparam int TICK_W  = (C_CONTROL_RATE > 1) ? $clog2(C_CONTROL_RATE) : 1;
  localparam int PIX_W   = $clog2(C_PIXEL_COUNT + 1);
  localparam int BCNT_W  = $clog2(BIT_PERIOD);
  localparam int LATCH_W = $clog2(LATCH_CLKS);
  localparam int HB_W    = $clog2(HB_DIV);

  typedef enum logic [1:0] {
    COL_RED   = 2'd0,
    COL_GREEN = 2'd1,
    COL_BLUE  = 2'd2
  } colour_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  // GRB-ordered 24-bit word for the lit pixel
  function automatic logic [23:0] colour_word(input colour_e c);
    logic [23:0] w;
    case (c)
      COL_RED:   w = 24'h00_20_00;
      COL_GREEN: w = 24'h20_00_00;
      COL_BLUE:  w = 24'h00_00_20;
      default:   w = 24'h00_00_00;
    endcase
    return w;
  endfunction

  function automatic colour_e colour_next(input colour_e c);
    colour_e n;
    case (c)
      COL_RED:   n = COL_GREEN;
      COL_GREEN: n = COL_BLUE;
      COL_BLUE:  n = COL_RED;
      default:   n = COL_RED;
    endcase
    return n;
  endfunction

  // ---------------- animation tick ----------------
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick_q, tick_d;

  // tick counter next state
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    tick_d     = 1'b0;
    if (tick_cnt_q == TICK_W'(C_CONTROL_RATE - 1)) begin
      tick_cnt_d = '0;
      tick_d     = 1'b1;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
      tick_d     = 1'b0;
    end
  end

  // tick counter registers
  always_ff @(posedge clock_125m or negedge reset_125m) begin
    if (!reset_125m) begin
      tick_cnt_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick_d;
    end
  end

  // ---------------- chaser pattern ----------------
  logic [PIX_W-1:0] pos_q, pos_d;
  colour_e          colour_q, colour_d;

  // pattern next state: advance position, colour steps when position wraps
  always_comb begin
    pos_d    = pos_q;
    colour_d = colour_q;
    if (tick_q) begin
      if (pos_q == PIX_W'(C_PIXEL_COUNT - 1)) begin
        pos_d    = '0;
        colour_d = colour_next(colour_q);
      end else begin
        pos_d    = pos_q + PIX_W'(1);
        colour_d = colour_q;
      end
    end else begin
      pos_d    = pos_q;
      colour_d = colour_q;
    end
  end

  // pattern registers
  always_ff @(posedge clock_125m or negedge reset_125m) begin
    if (!reset_125m) begin
      pos_q    <= '0;
      colour_q <= COL_RED;
    end else begin
      pos_q    <= pos_d;
      colour_q <= colour_d;
    end
  end

  // ---------------- serialiser FSM ----------------
  state_e             state_q, state_d;
  logic [PIX_W-1:0]   pix_idx_q, pix_idx_d;
  logic [4:0]         bit_idx_q, bit_idx_d;
  logic [BCNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [LATCH_W-1:0] latch_cnt_q, latch_cnt_d;
  logic [PIX_W-1:0]   snap_pos_q, snap_pos_d;
  colour_e            snap_col_q, snap_col_d;
  logic               line_q, line_d;
  logic [23:0]        cur_word_s;
  logic               cur_bit_s;
  logic [BCNT_W-1:0]  high_len_s;

  // FSM next state; the line level is computed for the current bit slot and registered
  always_comb begin
    state_d     = state_q;
    pix_idx_d   = pix_idx_q;
    bit_idx_d   = bit_idx_q;
    bit_cnt_d   = bit_cnt_q;
    latch_cnt_d = latch_cnt_q;
    snap_pos_d  = snap_pos_q;
    snap_col_d  = snap_col_q;
    line_d      = 1'b0;
    cur_word_s  = (pix_idx_q == snap_pos_q) ? colour_word(snap_col_q) : 24'h00_00_00;
    cur_bit_s   = cur_word_s[bit_idx_q];
    high_len_s  = cur_bit_s ? BCNT_W'(T1_HIGH) : BCNT_W'(T0_HIGH);
    case (state_q)
      ST_IDLE: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        snap_pos_d = pos_q;
        snap_col_d = colour_q;
        pix_idx_d  = '0;
        bit_idx_d  = 5'd23;
        bit_cnt_d  = '0;
        state_d    = ST_SEND;
      end
      ST_SEND: begin
        line_d = (bit_cnt_q < high_len_s);
        if (bit_cnt_q == BCNT_W'(BIT_PERIOD - 1)) begin
          bit_cnt_d = '0;
          if (bit_idx_q == 5'd0) begin
            bit_idx_d = 5'd23;
            if (pix_idx_q == PIX_W'(C_PIXEL_COUNT - 1)) begin
              pix_idx_d   = '0;
              latch_cnt_d = '0;
              state_d     = ST_LATCH;
            end else begin
              pix_idx_d = pix_idx_q + PIX_W'(1);
            end
          end else begin
            bit_idx_d = bit_idx_q - 5'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BCNT_W'(1);
        end
      end
      ST_LATCH: begin
        // LOAD supplies the final low clock of the latch gap
        if (latch_cnt_q == LATCH_W'(LATCH_CLKS - 2)) begin
          state_d = ST_LOAD;
        end else begin
          latch_cnt_d = latch_cnt_q + LATCH_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and line registers
  always_ff @(posedge clock_125m or negedge reset_125m) begin
    if (!reset_125m) begin
      state_q     <= ST_IDLE;
      pix_idx_q   <= '0;
      bit_idx_q   <= 5'd0;
      bit_cnt_q   <= '0;
      latch_cnt_q <= '0;
      snap_pos_q  <= '0;
      snap_col_q  <= COL_RED;
      line_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_idx_q   <= pix_idx_d;
      bit_idx_q   <= bit_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      latch_cnt_q <= latch_cnt_d;
      snap_pos_q  <= snap_pos_d;
      snap_col_q  <= snap_col_d;
      line_q      <= line_d;
    end
  end

  // ---------------- heartbeat ----------------
  logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
  logic            leds_q, leds_d;

  // heartbeat divider next state
  always_comb begin
    hb_cnt_d = hb_cnt_q;
    leds_d   = leds_q;
    if (hb_cnt_q == HB_W'(HB_DIV - 1)) begin
      hb_cnt_d = '0;
      leds_d   = ~leds_q;
    end else begin
      hb_cnt_d = hb_cnt_q + HB_W'(1);
      leds_d   = leds_q;
    end
  end

  // heartbeat registers
  always_ff @(posedge clock_125m or negedge reset_125m) begin
    if (!reset_125m) begin
      hb_cnt_q <= '0;
      leds_q   <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      leds_q   <= leds_d;
    end
  end

  assign neopixel_drive1 = line_q;
  assign leds            = leds_q;

endmodule

// File: tb/tb_neopixel_top.sv
// Directed bench for neopixel_top: decodes the WS2812 stream by pulse width and
// checks frame content, bit/latch timing, reset behaviour and heartbeat period.
`timescale 1ns/1ps
module tb_neopixel_top;

  logic clk;
  logic rst1_n, rst2_n;
  logic np1, np2, leds1, leds2;
  int   n_cmp, n_err;

  localparam logic [23:0] W_RED   = 24'h00_20_00;
  localparam logic [23:0] W_GREEN = 24'h20_00_00;
  localparam logic [23:0] W_BLUE  = 24'h00_00_20;

  neopixel_top #(.C_SIM_MODE(1), .C_CONTROL_RATE(8000), .C_PIXEL_COUNT(12)) u_dut (
    .clock_125m(clk), .reset_125m(rst1_n), .neopixel_drive1(np1), .leds(leds1));

  // short chain with a fast tick to reach colour changes quickly
  neopixel_top #(.C_SIM_MODE(1), .C_CONTROL_RATE(3000), .C_PIXEL_COUNT(2)) u_dut2 (
    .clock_125m(clk), .reset_125m(rst2_n), .neopixel_drive1(np2), .leds(leds2));

  initial clk = 1'b0;
  always #4 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic line_of(input int w);
    return (w != 0) ? np2 : np1;
  endfunction

  task automatic wait_rise(input int w, output int n);
    n = 0;
    while (line_of(w) == 1'b0 && n < 60000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Starts on a sample where the line just went high; returns high and low sample counts
  task automatic pulse(input int w, output int h, output int l);
    h = 0;
    l = 0;
    while (line_of(w) == 1'b1 && h < 2000) begin
      @(negedge clk);
      h++;
    end
    while (line_of(w) == 1'b0 && l < 20000) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic check_frame(input int w, input string tag, input int npix, input int nchk,
                             input int exp_pix, input logic [23:0] exp_word);
    logic [23:0] word;
    int h, l, terr;
    terr = 0;
    for (int p = 0; p < nchk; p++) begin
      word = 24'h0;
      for (int b = 0; b < 24; b++) begin
        pulse(w, h, l);
        word = {word[22:0], (h > 75)};
        if (!(h == 50 || h == 100)) terr++;
        if (p == npix - 1 && b == 23) check_eq({tag, "_gap"}, h + l, 556);
        else if (h + l != 156) terr++;
      end
      check_eq($sformatf("%s_px%0d", tag, p), word, (p == exp_pix) ? exp_word : 24'h0);
    end
    check_eq({tag, "_timing"}, terr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    rst1_n = 1'b0;
    rst2_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("rst_line", {np2, np1}, 0);
      check_eq("rst_leds", {leds2, leds1}, 0);
    end
    rst1_n = 1'b1;
    rst2_n = 1'b1;
    fork
      begin : main_seq
        int lat;
        wait_rise(0, lat);
        check_eq("first_rise", (lat <= 3 && np1 == 1'b1), 1);
        check_frame(0, "f1", 12, 12, 0, W_RED);
        check_frame(0, "f2", 12, 6, 5, W_RED);
        #1 rst1_n = 1'b0;
        #1 check_eq("rst_async", np1, 0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (np1 !== 1'b0 || leds1 !== 1'b0) n++;
        end
        check_eq("rst_hold", n, 0);
        rst1_n = 1'b1;
        wait_rise(0, lat);
        check_eq("restart_rise", (lat <= 3 && np1 == 1'b1), 1);
        check_frame(0, "restart", 12, 1, 0, W_RED);
      end
      begin : dut2_seq
        int lat2;
        wait_rise(1, lat2);
        check_eq("d2_first_rise", (lat2 <= 3 && np2 == 1'b1), 1);
        check_frame(1, "d2f1", 2, 2, 0, W_RED);
        check_frame(1, "d2f2", 2, 2, 0, W_GREEN);
        check_frame(1, "d2f3", 2, 2, 1, W_BLUE);
      end
      begin : hb_seq
        for (int k = 0; k < 16; k++) begin
          int t;
          logic old;
          t = 0;
          old = leds2;
          while (leds2 == old && t < 3000) begin
            @(negedge clk);
            t++;
          end
          check_eq($sformatf("hb_period%0d", k), t, 1024);
        end
      end
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
